// File: rtl/period_meter.sv
// Square-wave period / high-time meter. Counts clk cycles between synchronized
// rising edges and from a rising edge to the following falling edge.
module period_meter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             rise_s, fall_s;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_s = s2_q & ~s3_q;
  assign fall_s = ~s2_q & s3_q;

  // State and measurement registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      hi_cnt_q     <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      high_time_q  <= CNT_ZERO;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic. A rise wins over saturation, so the counter never wraps.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_cnt_d     = hi_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          cnt_d    = CNT_ONE;
          hi_cnt_d = CNT_ZERO;
          state_d  = MEAS;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      MEAS: begin
        if (rise_s) begin
          period_d     = cnt_q;
          high_time_d  = hi_cnt_q;
          meas_valid_d = 1'b1;
          locked_d     = 1'b1;
          cnt_d        = CNT_ONE;
          hi_cnt_d     = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          cnt_d     = CNT_ZERO;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall_s) begin
            hi_cnt_d = cnt_q;
          end else begin
            hi_cnt_d = hi_cnt_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter: a 24-bit instance and a 4-bit
// instance share clock, reset and input; each test checks the relevant one.
module tb_period_meter;

  logic        clk;
  logic        nreset;
  logic        sig_in;
  logic [23:0] period24, high24;
  logic        mv24, lk24, to24;
  logic [3:0]  period4, high4;
  logic        mv4, lk4, to4;

  int n_checks;
  int n_fail;

  period_meter #(.CNT_W(24)) dut24 (
    .clk(clk), .nreset(nreset), .sig_in(sig_in),
    .period(period24), .high_time(high24),
    .meas_valid(mv24), .locked(lk24), .timeout(to24)
  );

  period_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .nreset(nreset), .sig_in(sig_in),
    .period(period4), .high_time(high4),
    .meas_valid(mv4), .locked(lk4), .timeout(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    sig_in = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
  endtask

  // Reset held for two cycles while the input toggles: everything stays zero.
  task automatic test_reset();
    nreset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sig_in = (i == 0);
      tick();
      n_checks++;
      if ({period24, high24, mv24, lk24, to24} !== 51'd0) begin
        n_fail++;
        $display("FAIL reset24 cyc%0d: got p=%0d h=%0d mv=%b lk=%b to=%b, want all 0",
                 i, period24, high24, mv24, lk24, to24);
      end
      n_checks++;
      if ({period4, high4, mv4, lk4, to4} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset4 cyc%0d: got p=%0d h=%0d mv=%b lk=%b to=%b, want all 0",
                 i, period4, high4, mv4, lk4, to4);
      end
    end
    nreset = 1'b1;
  endtask

  // Period 8, high 4: rises at drive index 0,8,..,32; pulses appear 2 samples later.
  task automatic test_period8();
    int nmv;
    logic exp_mv;
    nmv = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      sig_in = ((i % 8) < 4);
      tick();
      exp_mv = (i >= 10) && ((i % 8) == 2);
      n_checks++;
      if (mv24 !== exp_mv || to24 !== 1'b0) begin
        n_fail++;
        $display("FAIL p8_pulse i=%0d: got mv=%b to=%b, want mv=%b to=0", i, mv24, to24, exp_mv);
      end
      if (exp_mv) begin
        nmv++;
        n_checks++;
        if (period24 !== 24'd8 || high24 !== 24'd4 || lk24 !== 1'b1) begin
          n_fail++;
          $display("FAIL p8_value i=%0d: got p=%0d h=%0d lk=%b, want p=8 h=4 lk=1",
                   i, period24, high24, lk24);
        end
      end
    end
    n_checks++;
    if (nmv != 4) begin
      n_fail++;
      $display("FAIL p8_count: got %0d, want 4", nmv);
    end
  endtask

  // High 3, low 7.
  task automatic test_period10();
    logic exp_mv;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      sig_in = ((i % 10) < 3);
      tick();
      exp_mv = (i >= 12) && ((i % 10) == 2);
      n_checks++;
      if (mv24 !== exp_mv) begin
        n_fail++;
        $display("FAIL p10_pulse i=%0d: got mv=%b, want %b", i, mv24, exp_mv);
      end
      if (exp_mv) begin
        n_checks++;
        if (period24 !== 24'd10 || high24 !== 24'd3 || lk24 !== 1'b1) begin
          n_fail++;
          $display("FAIL p10_value i=%0d: got p=%0d h=%0d lk=%b, want p=10 h=3 lk=1",
                   i, period24, high24, lk24);
        end
      end
    end
  endtask

  // 4-bit counter: measure 10/3, starve into timeout, then re-measure 7/2.
  task automatic test_timeout();
    logic v, exp_mv, exp_to;
    do_reset();
    for (int i = 0; i <= 70; i++) begin
      v = (i <= 2) || (i >= 10 && i <= 12) || (i >= 50 && i <= 51) || (i >= 57 && i <= 58);
      sig_in = v;
      tick();
      exp_mv = (i == 12) || (i == 59);
      exp_to = (i == 27);
      n_checks++;
      if (mv4 !== exp_mv || to4 !== exp_to) begin
        n_fail++;
        $display("FAIL to_pulse i=%0d: got mv=%b to=%b, want mv=%b to=%b",
                 i, mv4, to4, exp_mv, exp_to);
      end
      if (i == 12) begin
        n_checks++;
        if (period4 !== 4'd10 || high4 !== 4'd3 || lk4 !== 1'b1) begin
          n_fail++;
          $display("FAIL to_first i=%0d: got p=%0d h=%0d lk=%b, want p=10 h=3 lk=1",
                   i, period4, high4, lk4);
        end
      end
      if (i == 27) begin
        n_checks++;
        if (period4 !== 4'd10 || high4 !== 4'd3 || lk4 !== 1'b0) begin
          n_fail++;
          $display("FAIL to_hold i=%0d: got p=%0d h=%0d lk=%b, want p=10 h=3 lk=0",
                   i, period4, high4, lk4);
        end
      end
      if (i == 58) begin
        n_checks++;
        if (lk4 !== 1'b0) begin
          n_fail++;
          $display("FAIL to_unlocked i=%0d: got lk=%b, want 0", i, lk4);
        end
      end
      if (i == 59) begin
        n_checks++;
        if (period4 !== 4'd7 || high4 !== 4'd2 || lk4 !== 1'b1) begin
          n_fail++;
          $display("FAIL to_fresh i=%0d: got p=%0d h=%0d lk=%b, want p=7 h=2 lk=1",
                   i, period4, high4, lk4);
        end
      end
    end
  endtask

  // 4-bit counter: rises exactly 15 apart measure 15 with no timeout.
  task automatic test_max_period();
    logic exp_mv;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      sig_in = ((i % 15) < 5);
      tick();
      exp_mv = (i == 17) || (i == 32);
      n_checks++;
      if (mv4 !== exp_mv || to4 !== 1'b0) begin
        n_fail++;
        $display("FAIL max_pulse i=%0d: got mv=%b to=%b, want mv=%b to=0", i, mv4, to4, exp_mv);
      end
      if (exp_mv) begin
        n_checks++;
        if (period4 !== 4'd15 || high4 !== 4'd5 || lk4 !== 1'b1) begin
          n_fail++;
          $display("FAIL max_value i=%0d: got p=%0d h=%0d lk=%b, want p=15 h=5 lk=1",
                   i, period4, high4, lk4);
        end
      end
    end
  endtask

  // One-cycle reset while locked: outputs clear, two new rises needed.
  task automatic test_mid_reset();
    logic exp_mv;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      sig_in = ((i % 8) < 4);
      nreset = (i != 21);
      tick();
      exp_mv = (i == 10) || (i == 18) || (i == 34);
      n_checks++;
      if (mv24 !== exp_mv) begin
        n_fail++;
        $display("FAIL mr_pulse i=%0d: got mv=%b, want %b", i, mv24, exp_mv);
      end
      if (i == 20) begin
        n_checks++;
        if (lk24 !== 1'b1) begin
          n_fail++;
          $display("FAIL mr_locked i=%0d: got lk=%b, want 1", i, lk24);
        end
      end
      if (i == 21) begin
        n_checks++;
        if ({period24, high24, mv24, lk24, to24} !== 51'd0) begin
          n_fail++;
          $display("FAIL mr_clear: got p=%0d h=%0d mv=%b lk=%b to=%b, want all 0",
                   period24, high24, mv24, lk24, to24);
        end
      end
      if (i == 34) begin
        n_checks++;
        if (period24 !== 24'd8 || high24 !== 24'd4 || lk24 !== 1'b1) begin
          n_fail++;
          $display("FAIL mr_value: got p=%0d h=%0d lk=%b, want p=8 h=4 lk=1",
                   period24, high24, lk24);
        end
      end
    end
    nreset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nreset   = 1'b0;
    sig_in   = 1'b0;
    test_reset();
    test_period8();
    test_period10();
    test_timeout();
    test_max_period();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
